// File: rtl/demux1to4_reg.sv
// demux1to4_reg
//    Routes an input word to one of four registered output channels
//    selected by sel. Each channel has a one-word buffer with a valid flag.
//    It uses a ready/valid handshake on both sides. Each channel can accept
//    a new word in the same cycle that its held word is consumed, so it
//    carries one word per cycle. Each channel also counts the words it has
//    received, wrapping modulo 256.
//
// Ports
//    clk        rising-edge clock
//    rst        asynchronous active-high reset (clears buffers and counters)
//    in_valid   input word present
//    in_data    input word [WIDTH]
//    sel        destination channel 0..3
//    in_ready   block accepts the input word this cycle (combinational)
//    out0..3    held word of channel n [WIDTH]
//    out_valid  bit n: channel n holds a word
//    out_ready  bit n: consumer of channel n takes its word this cycle
//    cnt0..3    words delivered into channel n, mod 256
module demux1to4_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       sel,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [7:0]       cnt0,
   output logic [7:0]       cnt1,
   output logic [7:0]       cnt2,
   output logic [7:0]       cnt3
);

   // The counter wraps from 255 to 0 and never saturates.
   function automatic logic [7:0] inc_wrap(input logic [7:0] v);
      return v + 8'd1;
   endfunction

   logic [WIDTH-1:0] data_p1 [4];
   logic [3:0]       vld_p1;
   logic [7:0]       cnt_p1  [4];
   logic [3:0]       load_p0;

   // in_ready looks only at the addressed channel. A full channel can
   // accept a new word when its consumer drains it on the same edge.
   // in_valid is deliberately not part of this term.
   assign in_ready = !vld_p1[sel] || out_ready[sel];

   always_comb begin
      load_p0 = 4'b0000;
      if (in_valid && in_ready) begin
         load_p0[sel] = 1'b1;
      end
   end

   // ---- stage p0 -> p1: channel buffer registers ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 4'b0000;
         for (int n = 0; n < 4; n++) begin
            data_p1[n] <= '0;
            cnt_p1[n]  <= 8'd0;
         end
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (load_p0[n]) begin
               // A load wins over a drain on the same edge.
               // The new word replaces the old one and the valid flag stays set.
               data_p1[n] <= in_data;
               vld_p1[n]  <= 1'b1;
               cnt_p1[n]  <= inc_wrap(cnt_p1[n]);
            end else if (vld_p1[n] && out_ready[n]) begin
               // The data stays in place after a drain; only the flag clears.
               vld_p1[n] <= 1'b0;
            end
         end
      end
   end

   assign out0      = data_p1[0];
   assign out1      = data_p1[1];
   assign out2      = data_p1[2];
   assign out3      = data_p1[3];
   assign out_valid = vld_p1;
   assign cnt0      = cnt_p1[0];
   assign cnt1      = cnt_p1[1];
   assign cnt2      = cnt_p1[2];
   assign cnt3      = cnt_p1[3];

endmodule

// File: tb/tb_demux1to4_reg.sv
module tb_demux1to4_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic [1:0] sel;
   logic       in_ready;
   logic [7:0] out0, out1, out2, out3;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [7:0] cnt0, cnt1, cnt2, cnt3;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         ch;
      logic [7:0] data;
      logic [7:0] cnt;
   } exp_t;
   exp_t sbq[$];

   // reference state
   logic [3:0] m_vld;
   logic [7:0] m_data [4];
   logic [7:0] m_cnt  [4];

   demux1to4_reg #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .sel(sel),
      .in_ready(in_ready), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
      .out_valid(out_valid), .out_ready(out_ready),
      .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] get_out(input int n);
      case (n)
         0: return out0;
         1: return out1;
         2: return out2;
         default: return out3;
      endcase
   endfunction

   function automatic logic [7:0] get_cnt(input int n);
      case (n)
         0: return cnt0;
         1: return cnt1;
         2: return cnt2;
         default: return cnt3;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_vld = 4'b0000;
      for (int n = 0; n < 4; n++) begin
         m_data[n] = 8'h00;
         m_cnt[n]  = 8'h00;
      end
      sbq.delete();
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".out_valid"}, {28'd0, out_valid}, {28'd0, m_vld});
      for (int n = 0; n < 4; n++) begin
         chk($sformatf("%s.out%0d", tag, n), {24'd0, get_out(n)}, {24'd0, m_data[n]});
         chk($sformatf("%s.cnt%0d", tag, n), {24'd0, get_cnt(n)}, {24'd0, m_cnt[n]});
      end
   endtask

   // One clock cycle. It drives the inputs, checks in_ready against the
   // model, and then clocks the DUT. After the edge it pops the scoreboard
   // entry for any transfer and checks the full state.
   task automatic step(input logic iv, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] ordy, input string tag);
      logic exp_rdy;
      logic xfer;
      exp_t e;
      in_valid  = iv;
      sel       = s;
      in_data   = d;
      out_ready = ordy;
      #1;
      exp_rdy = !m_vld[s] || ordy[s];
      chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
      xfer = iv && exp_rdy;
      if (xfer) begin
         e.ch = int'(s); e.data = d; e.cnt = m_cnt[s] + 8'd1;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      for (int n = 0; n < 4; n++) begin
         if (xfer && int'(s) == n) begin
            m_vld[n]  = 1'b1;
            m_data[n] = d;
            m_cnt[n]  = m_cnt[n] + 8'd1;
         end else if (m_vld[n] && ordy[n]) begin
            m_vld[n] = 1'b0;
         end
      end
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk({tag, ".sb_data"}, {24'd0, get_out(e.ch)}, {24'd0, e.data});
         chk({tag, ".sb_cnt"},  {24'd0, get_cnt(e.ch)}, {24'd0, e.cnt});
      end
      chk_state(tag);
   endtask

   initial begin
      logic [7:0] last;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; sel = 2'd0; out_ready = 4'b0000;
      model_reset();
      #12;
      // reset state
      chk_state("reset");
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s); #1;
         chk($sformatf("reset.in_ready_sel%0d", s), {31'd0, in_ready}, 32'd1);
      end
      @(negedge clk);
      rst = 1'b0;

      // a single word into channel 2
      step(1'b1, 2'd2, 8'hA5, 4'b0000, "first_word");
      chk("first_word.out_valid_const", {28'd0, out_valid}, 32'h4);
      chk("first_word.out2_const", {24'd0, out2}, 32'hA5);
      chk("first_word.cnt2_const", {24'd0, cnt2}, 32'h1);

      // channel 1 full and not drained, so it stalls; channel 3 proceeds
      step(1'b1, 2'd1, 8'h77, 4'b0000, "fill_ch1");
      step(1'b1, 2'd1, 8'h3C, 4'b0000, "ch1_stall");
      chk("ch1_stall.out1_const", {24'd0, out1}, 32'h77);
      chk("ch1_stall.cnt1_const", {24'd0, cnt1}, 32'h1);
      in_valid = 1'b1; sel = 2'd1; in_data = 8'h3C; out_ready = 4'b0000; #1;
      chk("sel_change.in_ready_ch1", {31'd0, in_ready}, 32'd0);
      step(1'b1, 2'd3, 8'h3C, 4'b0000, "sel_change_ch3");
      chk("sel_change.out3_const", {24'd0, out3}, 32'h3C);

      // a load and a drain on the same channel in one cycle
      step(1'b1, 2'd0, 8'h11, 4'b0000, "fill_ch0");
      step(1'b1, 2'd0, 8'h22, 4'b0001, "replace_ch0");
      chk("replace_ch0.out0_const", {24'd0, out0}, 32'h22);

      // fill every channel, then pulse an asynchronous reset between edges
      for (int n = 0; n < 4; n++)
         step(1'b1, 2'(n), 8'hC0 + 8'(n), 4'b0001 << n, "fill_all");
      chk("fill_all.out_valid_const", {28'd0, out_valid}, 32'hF);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk_state("async_rst");
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s); #0;
         chk($sformatf("async_rst.in_ready_sel%0d", s), {31'd0, in_ready}, 32'd1);
      end
      #1 rst = 1'b0;

      // sel and in_data are ignored while in_valid is low
      for (int i = 0; i < 8; i++)
         step(1'b0, 2'(i % 4), 8'($urandom), 4'b1111, "idle");
      chk("idle.out_valid_const", {28'd0, out_valid}, 32'h0);

      // 256 back-to-back words into channel 3 wrap the counter
      last = 8'h00;
      for (int i = 0; i < 256; i++) begin
         last = 8'(i * 7 + 3);
         step(1'b1, 2'd3, last, 4'b1000, "wrap");
      end
      chk("wrap.cnt3_const", {24'd0, cnt3}, 32'h0);
      chk("wrap.out3_last", {24'd0, out3}, {24'd0, last});

      // random traffic
      for (int i = 0; i < 60; i++)
         step(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom), "random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
